// File: rtl/maquina_pkg.sv
// Shared definitions for the vending-machine sequencer.
package maquina_pkg;

    // State encoding doubles as the phase timer's control input; 0 holds the timer.
    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        SELECAO   = 2'd1,
        PAGAMENTO = 2'd2,
        ENTREGA   = 2'd3
    } estado_t;

    // Default product prices and payment timeout.
    localparam int CRED_W_PADRAO  = 8;
    localparam int PRECO0_PADRAO  = 5;
    localparam int PRECO1_PADRAO  = 10;
    localparam int PRECO2_PADRAO  = 15;
    localparam int PRECO3_PADRAO  = 20;
    localparam int TIMEOUT_PADRAO = 8;

endpackage

// File: rtl/detector_borda.sv
// Falling-edge detector for one active-low timer strobe.
// History resets to 1 so a strobe already low after reset still counts as one fall.
module detector_borda (
    input  logic clk,
    input  logic rst,
    input  logic sinal,
    output logic evento
);

    logic anterior;

    // Remember the strobe level of the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) anterior <= 1'b1;
        else     anterior <= sinal;
    end

    // One pulse per 1->0 transition, regardless of how long the strobe stays low.
    assign evento = anterior & ~sinal;

endmodule

// File: rtl/controlador_maquina.sv
// Main vending-machine sequencer: product selection, coin crediting,
// dispense/change decisions paced by the phase timer strobes.
// Optional feature: define TIMEOUT_EN to refund automatically after
// TIMEOUT_CICLOS end-of-cycle events in PAGAMENTO without a coin.
module controlador_maquina
    import maquina_pkg::*;
#(
    parameter int CRED_W         = CRED_W_PADRAO,
    parameter int PRECO0         = PRECO0_PADRAO,
    parameter int PRECO1         = PRECO1_PADRAO,
    parameter int PRECO2         = PRECO2_PADRAO,
    parameter int PRECO3         = PRECO3_PADRAO,
    parameter int TIMEOUT_CICLOS = TIMEOUT_PADRAO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tempoTeclado,
    input  logic              tempoAcumulador,
    input  logic              tempo,
    input  logic              tecla_valida,
    input  logic [1:0]        tecla,
    input  logic              moeda_valida,
    input  logic [CRED_W-1:0] moeda_valor,
    input  logic              cancelar,
    output logic [1:0]        estado,
    output logic [1:0]        produto,
    output logic [CRED_W-1:0] credito,
    output logic              liberar,
    output logic              troco_valido,
    output logic [CRED_W-1:0] troco
);

    // Sum clamped at the all-ones value so credit never wraps.
    function automatic logic [CRED_W-1:0] soma_sat(input logic [CRED_W-1:0] a,
                                                   input logic [CRED_W-1:0] b);
        logic [CRED_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CRED_W] ? {CRED_W{1'b1}} : s[CRED_W-1:0];
    endfunction

    function automatic logic [CRED_W-1:0] preco_de(input logic [1:0] cod);
        case (cod)
            2'd0:    return CRED_W'(PRECO0);
            2'd1:    return CRED_W'(PRECO1);
            2'd2:    return CRED_W'(PRECO2);
            default: return CRED_W'(PRECO3);
        endcase
    endfunction

    // Phase events from the three timer strobes.
    logic ev_teclado, ev_acum, ev_tempo;

    detector_borda u_borda_teclado (.clk(clk), .rst(rst), .sinal(tempoTeclado),    .evento(ev_teclado));
    detector_borda u_borda_acum    (.clk(clk), .rst(rst), .sinal(tempoAcumulador), .evento(ev_acum));
    detector_borda u_borda_tempo   (.clk(clk), .rst(rst), .sinal(tempo),           .evento(ev_tempo));

    estado_t           est_q, est_n;
    logic [1:0]        produto_n;
    logic [CRED_W-1:0] preco_q, preco_n;
    logic [CRED_W-1:0] credito_n;
    logic [CRED_W-1:0] pend_q, pend_n;
    logic              liberar_n, troco_valido_n;
    logic [CRED_W-1:0] troco_n;

    // Pending coins including one arriving this cycle; feeds both the
    // accumulator commit and any refund so a same-cycle coin is never lost.
    logic [CRED_W-1:0] pend_soma;
    logic [CRED_W-1:0] total_reemb;
    logic              reembolsar;

    assign pend_soma   = moeda_valida ? soma_sat(pend_q, moeda_valor) : pend_q;
    assign total_reemb = soma_sat(credito, pend_soma);

`ifdef TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CICLOS + 1);
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] cnt_mais;
    assign cnt_mais = cnt_q + CNT_W'(1);
`endif

    // State and output registers; every output is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            est_q        <= OCIOSO;
            produto      <= 2'd0;
            preco_q      <= '0;
            credito      <= '0;
            pend_q       <= '0;
            liberar      <= 1'b0;
            troco_valido <= 1'b0;
            troco        <= '0;
`ifdef TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            est_q        <= est_n;
            produto      <= produto_n;
            preco_q      <= preco_n;
            credito      <= credito_n;
            pend_q       <= pend_n;
            liberar      <= liberar_n;
            troco_valido <= troco_valido_n;
            troco        <= troco_n;
`ifdef TIMEOUT_EN
            cnt_q        <= cnt_n;
`endif
        end
    end

    // Next-state and next-output logic; cancel/refund overrides everything last.
    always_comb begin
        est_n          = est_q;
        produto_n      = produto;
        preco_n        = preco_q;
        credito_n      = credito;
        pend_n         = pend_q;
        liberar_n      = 1'b0;
        troco_valido_n = 1'b0;
        troco_n        = troco;
        reembolsar     = 1'b0;
`ifdef TIMEOUT_EN
        cnt_n          = cnt_q;
`endif

        case (est_q)
            OCIOSO: begin
                // No sale in progress: hand coins straight back.
                if (moeda_valida) begin
                    troco_n        = moeda_valor;
                    troco_valido_n = 1'b1;
                end
                if (tecla_valida) begin
                    produto_n = tecla;
                    preco_n   = preco_de(tecla);
                    est_n     = SELECAO;
                end
            end

            SELECAO: begin
                if (cancelar) begin
                    reembolsar = 1'b1;
                end else begin
                    // A key in the same cycle as the keypad event is still taken.
                    if (tecla_valida) begin
                        produto_n = tecla;
                        preco_n   = preco_de(tecla);
                    end
                    if (ev_teclado) est_n = PAGAMENTO;
                end
            end

            PAGAMENTO: begin
                if (cancelar) begin
                    reembolsar = 1'b1;
                end else begin
                    pend_n = pend_soma;
                    if (ev_acum) begin
                        credito_n = soma_sat(credito, pend_soma);
                        pend_n    = '0;
                    end
                    // Decision uses credit committed before this cycle.
                    if (ev_tempo && (credito >= preco_q)) est_n = ENTREGA;
`ifdef TIMEOUT_EN
                    if (moeda_valida)  cnt_n = '0;
                    else if (ev_tempo) cnt_n = cnt_mais;
                    if (!moeda_valida && ev_tempo && (credito < preco_q) &&
                        (cnt_mais == CNT_W'(TIMEOUT_CICLOS)))
                        reembolsar = 1'b1;
`endif
                end
            end

            ENTREGA: begin
                // Entered only with credito >= price, so no underflow.
                liberar_n      = 1'b1;
                troco_n        = credito - preco_q;
                troco_valido_n = (credito != preco_q);
                credito_n      = '0;
                pend_n         = '0;
                est_n          = OCIOSO;
            end

            default: est_n = OCIOSO;
        endcase

        if (reembolsar) begin
            troco_n        = total_reemb;
            troco_valido_n = (total_reemb != '0);
            credito_n      = '0;
            pend_n         = '0;
            est_n          = OCIOSO;
        end

`ifdef TIMEOUT_EN
        if (est_n != PAGAMENTO) cnt_n = '0;
`endif
    end

    assign estado = est_q;

endmodule

// File: tb/tb_controlador_maquina.sv
// Directed bench for controlador_maquina: a vector table for the main sale
// flow plus hand sequences for cancel, saturation, reset and timeout.
module tb_controlador_maquina;

    localparam int CRED_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              tempoTeclado, tempoAcumulador, tempo;
    logic              tecla_valida;
    logic [1:0]        tecla;
    logic              moeda_valida;
    logic [CRED_W-1:0] moeda_valor;
    logic              cancelar;
    logic [1:0]        estado;
    logic [1:0]        produto;
    logic [CRED_W-1:0] credito;
    logic              liberar;
    logic              troco_valido;
    logic [CRED_W-1:0] troco;

    int comparados = 0;
    int erros      = 0;

    controlador_maquina #(
        .CRED_W(CRED_W), .PRECO0(5), .PRECO1(10), .PRECO2(15), .PRECO3(20),
        .TIMEOUT_CICLOS(3)
    ) dut (
        .clk(clk), .rst(rst),
        .tempoTeclado(tempoTeclado), .tempoAcumulador(tempoAcumulador), .tempo(tempo),
        .tecla_valida(tecla_valida), .tecla(tecla),
        .moeda_valida(moeda_valida), .moeda_valor(moeda_valor),
        .cancelar(cancelar),
        .estado(estado), .produto(produto), .credito(credito),
        .liberar(liberar), .troco_valido(troco_valido), .troco(troco)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tv;  logic [1:0] tk;
        logic       mv;  logic [7:0] mval;
        logic       cc;
        logic       tt;  logic ta;  logic te;
        logic [1:0] e_est; logic [1:0] e_prod; logic [7:0] e_cred;
        logic       e_lib; logic e_tvld; logic [7:0] e_troco;
    } vetor_t;

    vetor_t tab[21];

    function automatic vetor_t mk(input logic tv, input logic [1:0] tk, input logic mv,
                                  input logic [7:0] mval, input logic cc, input logic tt,
                                  input logic ta, input logic te, input logic [1:0] e_est,
                                  input logic [1:0] e_prod, input logic [7:0] e_cred,
                                  input logic e_lib, input logic e_tvld, input logic [7:0] e_troco);
        vetor_t v;
        v.tv = tv; v.tk = tk; v.mv = mv; v.mval = mval; v.cc = cc;
        v.tt = tt; v.ta = ta; v.te = te;
        v.e_est = e_est; v.e_prod = e_prod; v.e_cred = e_cred;
        v.e_lib = e_lib; v.e_tvld = e_tvld; v.e_troco = e_troco;
        return v;
    endfunction

    task automatic chk(input string nome, input int unsigned atual, input int unsigned esperado);
        comparados++;
        if (atual != esperado) begin
            erros++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic ocioso();
        tecla_valida = 0; tecla = 0; moeda_valida = 0; moeda_valor = 0; cancelar = 0;
        tempoTeclado = 1; tempoAcumulador = 1; tempo = 1;
    endtask

    task automatic chk_saidas(input string nome, input int e_est, input int e_cred,
                              input int e_lib, input int e_tvld);
        chk({nome, ".estado"},       estado,       e_est);
        chk({nome, ".credito"},      credito,      e_cred);
        chk({nome, ".liberar"},      liberar,      e_lib);
        chk({nome, ".troco_valido"}, troco_valido, e_tvld);
    endtask

    // Select product cod and advance to PAGAMENTO via a keypad fall.
    task automatic ate_pagamento(input logic [1:0] cod);
        tecla_valida = 1; tecla = cod; ciclo(); ocioso();
        tempoTeclado = 0; ciclo(); ocioso();
    endtask

    // Coin plus accumulator fall in the same cycle, then release the strobe.
    task automatic moeda_acum(input logic [7:0] v);
        moeda_valida = 1; moeda_valor = v; tempoAcumulador = 0; ciclo(); ocioso(); ciclo();
    endtask

    initial begin
        ocioso();
        rst = 1;
        ciclo(); ciclo();
        chk_saidas("reset", 0, 0, 0, 0);
        chk("reset.produto", produto, 0);
        chk("reset.troco",   troco,   0);
        rst = 0;

        //          tv tk mv mval cc tt ta te | est prod cred lib tvld troco
        tab[0]  = mk(0, 0, 0,  0, 0, 1, 1, 1,  0, 0,  0, 0, 0, 0);
        tab[1]  = mk(1, 1, 0,  0, 0, 1, 1, 1,  1, 1,  0, 0, 0, 0);
        tab[2]  = mk(0, 0, 0,  0, 0, 0, 1, 1,  2, 1,  0, 0, 0, 0);
        tab[3]  = mk(0, 0, 0,  0, 0, 0, 1, 1,  2, 1,  0, 0, 0, 0);
        tab[4]  = mk(0, 0, 1,  5, 0, 1, 1, 1,  2, 1,  0, 0, 0, 0);
        tab[5]  = mk(0, 0, 0,  0, 0, 1, 0, 1,  2, 1,  5, 0, 0, 0);
        tab[6]  = mk(0, 0, 0,  0, 0, 1, 1, 0,  2, 1,  5, 0, 0, 0);
        tab[7]  = mk(0, 0, 1,  5, 0, 1, 1, 1,  2, 1,  5, 0, 0, 0);
        tab[8]  = mk(0, 0, 0,  0, 0, 1, 0, 1,  2, 1, 10, 0, 0, 0);
        tab[9]  = mk(0, 0, 0,  0, 0, 1, 1, 0,  3, 1, 10, 0, 0, 0);
        tab[10] = mk(0, 0, 0,  0, 0, 1, 1, 1,  0, 1,  0, 1, 0, 0);
        tab[11] = mk(0, 0, 0,  0, 0, 1, 1, 1,  0, 1,  0, 0, 0, 0);
        tab[12] = mk(1, 0, 0,  0, 0, 1, 1, 1,  1, 0,  0, 0, 0, 0);
        tab[13] = mk(0, 0, 0,  0, 0, 0, 1, 1,  2, 0,  0, 0, 0, 0);
        tab[14] = mk(0, 0, 1, 10, 0, 1, 1, 1,  2, 0,  0, 0, 0, 0);
        tab[15] = mk(0, 0, 0,  0, 0, 1, 0, 1,  2, 0, 10, 0, 0, 0);
        tab[16] = mk(0, 0, 0,  0, 0, 1, 1, 0,  3, 0, 10, 0, 0, 0);
        tab[17] = mk(0, 0, 0,  0, 0, 1, 1, 1,  0, 0,  0, 1, 1, 5);
        tab[18] = mk(0, 0, 0,  0, 0, 1, 1, 1,  0, 0,  0, 0, 0, 5);
        tab[19] = mk(0, 0, 1,  3, 0, 1, 1, 1,  0, 0,  0, 0, 1, 3);
        tab[20] = mk(0, 0, 0,  0, 0, 1, 1, 1,  0, 0,  0, 0, 0, 3);

        for (int i = 0; i < 21; i++) begin
            tecla_valida = tab[i].tv; tecla = tab[i].tk;
            moeda_valida = tab[i].mv; moeda_valor = tab[i].mval;
            cancelar = tab[i].cc;
            tempoTeclado = tab[i].tt; tempoAcumulador = tab[i].ta; tempo = tab[i].te;
            ciclo();
            chk($sformatf("vec%0d.estado", i),  estado,  tab[i].e_est);
            chk($sformatf("vec%0d.produto", i), produto, tab[i].e_prod);
            chk($sformatf("vec%0d.credito", i), credito, tab[i].e_cred);
            chk($sformatf("vec%0d.liberar", i), liberar, tab[i].e_lib);
            chk($sformatf("vec%0d.troco_valido", i), troco_valido, tab[i].e_tvld);
            if (tab[i].e_tvld) chk($sformatf("vec%0d.troco", i), troco, tab[i].e_troco);
        end
        ocioso();

        // Cancel in the same cycle as an end-of-cycle event with enough credit.
        ate_pagamento(2'd0);
        moeda_acum(8'd5);
        moeda_valida = 1; moeda_valor = 2; ciclo(); ocioso();
        chk("cancel.credito_antes", credito, 5);
        tempo = 0; cancelar = 1; ciclo(); ocioso();
        chk_saidas("cancel", 0, 0, 0, 1);
        chk("cancel.troco", troco, 7);
        ciclo();
        chk("cancel.pulso_um_ciclo", troco_valido, 0);
        chk("cancel.sem_liberar", liberar, 0);

        // Credit saturation; the same-cycle coin is included in the commit.
        ate_pagamento(2'd1);
        moeda_acum(8'd250);
        chk("sat.credito_250", credito, 250);
        moeda_acum(8'd10);
        chk("sat.credito_255", credito, 255);
        cancelar = 1; ciclo(); ocioso();
        chk("sat.troco", troco, 255);
        chk("sat.troco_valido", troco_valido, 1);
        chk("sat.estado", estado, 0);

        // Key re-latched in the same cycle as the keypad event; exact payment.
        tecla_valida = 1; tecla = 1; ciclo(); ocioso();
        tecla_valida = 1; tecla = 3; tempoTeclado = 0; ciclo(); ocioso();
        chk("relatch.estado", estado, 2);
        chk("relatch.produto", produto, 3);
        moeda_acum(8'd20);
        tempo = 0; ciclo(); ocioso();
        chk("exato.estado", estado, 3);
        ciclo();
        chk_saidas("exato", 0, 0, 1, 0);

        // Reset mid-operation drops credit without a refund pulse.
        ate_pagamento(2'd2);
        moeda_acum(8'd7);
        chk("rstmeio.credito_antes", credito, 7);
        rst = 1; ciclo(); rst = 0;
        chk_saidas("rstmeio", 0, 0, 0, 0);
        chk("rstmeio.produto", produto, 0);
        ciclo();
        chk("rstmeio.troco_valido", troco_valido, 0);

        // End-of-cycle events with insufficient credit and no coins.
        ate_pagamento(2'd1);
        moeda_acum(8'd5);
        for (int k = 0; k < 3; k++) begin
            tempo = 0; ciclo(); ocioso();
            if (k < 2) begin
                chk($sformatf("timeout.espera%0d", k), estado, 2);
                ciclo();
            end
        end
`ifdef TIMEOUT_EN
        chk_saidas("timeout", 0, 0, 0, 1);
        chk("timeout.troco", troco, 5);
`else
        chk_saidas("sem_timeout", 2, 5, 0, 0);
        ciclo(); ciclo();
        chk("sem_timeout.estado_depois", estado, 2);
        cancelar = 1; ciclo(); ocioso();
        chk("sem_timeout.troco", troco, 5);
        chk("sem_timeout.troco_valido", troco_valido, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, erros);
        $finish;
    end

endmodule
